song_recorder: RTL and testbench
================================

// Module: song_recorder
// PURPOSE
//  Write-side counterpart of the song engine: samples the player's 12-key one-hot
//  keyboard once per beat and run-length encodes it into {note_id[7:4], beats[3:0]}
//  map entries, in the same format the engine plays back. Sits between keyboard
//  debounce and the song-map RAM write port; records a song for later replay.
// PARAMETERS
//  MAP_DEPTH  42  number of map entries the RAM holds; writes stop at this count
//  ADDR_W     6   width of wr_addr / entry_count; must satisfy 2**ADDR_W >= MAP_DEPTH
// PORTS
//  game_clock   in   1       single clock; all logic on posedge
//  reset        in   1       synchronous, active-high
//  record_en    in   1       level: high = record, low = stop and flush
//  beat_en      in   1       one-cycle strobe, one per beat; sample point for keys
//  keys         in   12      one-hot key state, bit0 = lowest note; 0 = rest
//  wr_en        out  1       one-cycle write strobe to the map RAM
//  wr_addr      out  ADDR_W  entry index for wr_data
//  wr_data      out  8       {note_id[3:0], beats[3:0]}
//  entry_count  out  ADDR_W  entries written since the last recording started
//  busy         out  1       high in RECORD or FLUSH
//  overflow     out  1       sticky: a run was lost because the map was full
// BEHAVIOUR
//  Reset: state=IDLE; wr_en, wr_addr, wr_data, entry_count, busy, overflow all 0;
//   pending run cleared. RAM contents are not touched. Reset wins over all inputs.
//  Encoding: keys==0 -> note_id 15 (rest). Otherwise note_id = index of the lowest
//   set bit (0..11); extra set bits are ignored. Ids 12-14 are never produced.
//  Pending run: run_id[3:0], run_len[3:0]; run_len==0 means no run.
//  States:
//   IDLE:   record_en=1 -> RECORD; clear entry_count, wr_addr, overflow, run_len.
//   RECORD: record_en=0 -> FLUSH; beat_en is ignored in that cycle.
//           On beat_en with sampled id s:
//            run_len==0            -> start run (s,1), no write
//            s==run_id, run_len<15 -> run_len+1, no write
//            otherwise             -> emit (run_id,run_len); start run (s,1)
//   FLUSH:  run_len!=0 -> emit the pending run. Always -> DONE next cycle.
//   DONE:   busy=0; wait for record_en=0, then -> IDLE. This stops an
//           immediate re-record from clobbering the map.
//  Emit: registered. wr_en is high exactly one cycle, the cycle after the
//   triggering beat_en or FLUSH entry. wr_addr = entry_count before the increment;
//   entry_count increments in the same cycle wr_en is high.
//  A run longer than 15 beats splits into back-to-back entries with the same id.
//   Example: 17 beats of C gives (0,15) then (0,2).
//  Full: when an emit is due and entry_count==MAP_DEPTH, no write occurs,
//   overflow is set, and state goes to DONE. The pending run is discarded.
//   entry_count saturates at MAP_DEPTH.
//  wr_data/wr_addr hold their last value when wr_en=0.
//  beat_en while not in RECORD is ignored.
//  keys are sampled only on beat_en cycles and are assumed synchronous upstream.
// TESTING
//  1 reset; record_en=1; beats with keys C,C,G,G,rest -> after drop of record_en
//    writes {0,2}@0, {7,2}@1, {15,1}@2; entry_count=3; busy falls; overflow=0.
//  2 hold keys=12'h080 for 17 beats then stop -> {7,15}@0, {7,2}@1, entry_count=2.
//  3 keys=12'h021 (two keys) on every beat for 3 beats -> single entry {0,3}.
//  4 MAP_DEPTH=4; alternate C/D on every beat for 6 beats, then stop -> 4 writes
//    at addr 0-3, overflow=1, state DONE, no wr_en after the 4th write.
//  5 assert reset while in RECORD with a pending run -> next cycle all outputs 0,
//    no wr_en is issued; a fresh record starts at addr 0.
//  6 record_en drops in the same cycle as beat_en -> that beat is not counted;
//    the flush writes the prior run length. Re-raising record_en while in DONE
//    without first dropping it -> no new recording starts.

Source files
------------

// File: rtl/song_recorder_if.sv
// ---------------------------------------------------------------------------
// song_recorder_if
//   Write port from the song recorder into the song-map RAM.
//
//   Handshake: wr_en is a valid-only strobe. The RAM has no ready signal. It
//   must accept a write in every cycle where wr_en=1. wr_addr and wr_data are
//   meaningful only while wr_en=1. At all other times they hold their last
//   value.
//
//   Signals
//     wr_en    1       one-cycle write strobe
//     wr_addr  ADDR_W  entry index being written
//     wr_data  8       {note_id[3:0], beats[3:0]}
//
//   Modports
//     master  the recorder (drives the port)
//     slave   the map RAM (receives the port)
// ---------------------------------------------------------------------------
interface song_recorder_if #(
  parameter int ADDR_W = 6
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/song_recorder.sv
// ---------------------------------------------------------------------------
// song_recorder
//   Samples a 12-key one-hot keyboard once per beat. It run-length encodes the
//   samples into {note_id, beats} song-map entries, in the same format that
//   the song engine plays back.
//
//   Parameters
//     MAP_DEPTH    number of map entries the RAM holds; writes stop there
//     ADDR_W       width of wr_addr / entry_count (2**ADDR_W >= MAP_DEPTH)
//
//   Ports
//     game_clock   single clock; all logic on posedge
//     reset        synchronous, active-high
//     record_en    level: high = record, low = stop and flush
//     beat_en      one-cycle strobe per beat; keys are sampled only then
//     keys         one-hot key state, bit0 = lowest note, 0 = rest
//     wr_port      map RAM write port (wr_en / wr_addr / wr_data)
//     entry_count  entries written since the last recording started
//     busy         high while recording or flushing
//     overflow     sticky: a run was lost because the map was full
//     state_dbg    current FSM state:
//                  0 = IDLE, 1 = RECORD, 2 = FLUSH, 3 = DONE
// ---------------------------------------------------------------------------
module song_recorder #(
  parameter int MAP_DEPTH = 42,
  parameter int ADDR_W    = 6
) (
  input  logic              game_clock,
  input  logic              reset,
  input  logic              record_en,
  input  logic              beat_en,
  input  logic [11:0]       keys,
  song_recorder_if.master   wr_port,
  output logic [ADDR_W-1:0] entry_count,
  output logic              busy,
  output logic              overflow,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] FULL_COUNT = ADDR_W'(MAP_DEPTH);
  localparam logic [3:0]        REST_ID    = 4'd15;
  localparam logic [3:0]        MAX_LEN    = 4'd15;

  state_t state, state_n;

  // Pending run. A run_len of 0 means there is no run.
  logic [3:0] run_id;
  logic [3:0] run_len;

  // Registered write port.
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;

  // Datapath controls produced by the FSM.
  logic       clear_rec;   // new recording: zero the counters and the run
  logic       start_run;   // load (sample_id, 1) into the pending run
  logic       extend_run;  // pending run grows by one beat
  logic       clear_run;   // drop the pending run
  logic       emit;        // write the pending run to the map
  logic       set_ovf;     // an emit was due but the map is full

  logic [3:0] sample_id;
  logic       map_full;

  // -------------------------------------------------------------------------
  // Key encoder. The lowest set bit wins. Scanning from the top down lets the
  // lowest index overwrite any higher one. No key pressed encodes as rest.
  // -------------------------------------------------------------------------
  always_comb begin
    sample_id = REST_ID;
    for (int i = 11; i >= 0; i--) begin
      if (keys[i]) begin
        sample_id = 4'(i);
      end
    end
  end

  assign map_full = (entry_count == FULL_COUNT);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge game_clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and datapath controls
  // -------------------------------------------------------------------------
  always_comb begin
    state_n    = state;
    clear_rec  = 1'b0;
    start_run  = 1'b0;
    extend_run = 1'b0;
    clear_run  = 1'b0;
    emit       = 1'b0;
    set_ovf    = 1'b0;

    unique case (state)
      IDLE: begin
        if (record_en) begin
          state_n   = RECORD;
          clear_rec = 1'b1;
        end
      end

      RECORD: begin
        if (!record_en) begin
          // Stopping takes priority. A beat that arrives in the same cycle
          // is not counted.
          state_n = FLUSH;
        end else if (beat_en) begin
          if (run_len == 4'd0) begin
            start_run = 1'b1;
          end else if (sample_id == run_id && run_len != MAX_LEN) begin
            extend_run = 1'b1;
          end else if (map_full) begin
            // The finished run has no room in the map. The whole recording
            // ends here, and the new sample is discarded as well.
            set_ovf   = 1'b1;
            clear_run = 1'b1;
            state_n   = DONE;
          end else begin
            // A different note, or a run that is already 15 beats long.
            // Write out the old run and start a new one. The new run may
            // have the same id as the old one.
            emit      = 1'b1;
            start_run = 1'b1;
          end
        end
      end

      FLUSH: begin
        state_n   = DONE;
        clear_run = 1'b1;
        if (run_len != 4'd0) begin
          if (map_full) begin
            set_ovf = 1'b1;
          end else begin
            emit = 1'b1;
          end
        end
      end

      DONE: begin
        // record_en must be seen low before the next recording can start.
        // Without this, an immediate re-record would overwrite the map.
        if (!record_en) begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: pending run, entry counter, overflow flag, write port
  // -------------------------------------------------------------------------
  always_ff @(posedge game_clock) begin
    if (reset) begin
      run_id      <= 4'd0;
      run_len     <= 4'd0;
      entry_count <= '0;
      overflow    <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'd0;
    end else begin
      wr_en_q <= emit;

      // wr_addr is the count before the increment. The count and the strobe
      // become visible in the same cycle.
      if (emit) begin
        wr_addr_q   <= entry_count;
        wr_data_q   <= {run_id, run_len};
        entry_count <= entry_count + ADDR_W'(1);
      end

      if (clear_rec) begin
        entry_count <= '0;
        wr_addr_q   <= '0;
        overflow    <= 1'b0;
      end

      if (set_ovf) begin
        overflow <= 1'b1;
      end

      if (clear_rec || clear_run) begin
        run_len <= 4'd0;
      end else if (start_run) begin
        run_id  <= sample_id;
        run_len <= 4'd1;
      end else if (extend_run) begin
        run_len <= run_len + 4'd1;
      end
    end
  end

  assign wr_port.wr_en   = wr_en_q;
  assign wr_port.wr_addr = wr_addr_q;
  assign wr_port.wr_data = wr_data_q;

  assign busy      = (state == RECORD) || (state == FLUSH);
  assign state_dbg = state;

endmodule

// File: tb/tb_song_recorder.sv
module tb_song_recorder;

  logic        game_clock = 1'b0;
  logic        reset      = 1'b0;
  logic        record_en  = 1'b0;
  logic        beat_en    = 1'b0;
  logic [11:0] keys       = 12'h000;

  // Main instance with default parameters
  song_recorder_if #(.ADDR_W(6)) wr_if ();
  logic [5:0] entry_count;
  logic       busy;
  logic       overflow;
  logic [1:0] state_dbg;

  // Small-map instance used to exercise the full-map behaviour
  song_recorder_if #(.ADDR_W(3)) wr_small_if ();
  logic [2:0] entry_count_small;
  logic       busy_small;
  logic       overflow_small;
  logic [1:0] state_dbg_small;

  int checks = 0;
  int errors = 0;

  // Scoreboards: {wr_addr, wr_data}
  logic [13:0] exp_q[$];
  logic [13:0] got_q[$];
  logic [10:0] exp_small_q[$];
  logic [10:0] got_small_q[$];

  song_recorder #(.MAP_DEPTH(42), .ADDR_W(6)) dut (
    .game_clock  (game_clock),
    .reset       (reset),
    .record_en   (record_en),
    .beat_en     (beat_en),
    .keys        (keys),
    .wr_port     (wr_if.master),
    .entry_count (entry_count),
    .busy        (busy),
    .overflow    (overflow),
    .state_dbg   (state_dbg)
  );

  song_recorder #(.MAP_DEPTH(4), .ADDR_W(3)) dut_small (
    .game_clock  (game_clock),
    .reset       (reset),
    .record_en   (record_en),
    .beat_en     (beat_en),
    .keys        (keys),
    .wr_port     (wr_small_if.master),
    .entry_count (entry_count_small),
    .busy        (busy_small),
    .overflow    (overflow_small),
    .state_dbg   (state_dbg_small)
  );

  // ---------------- clock / watchdog ----------------
  always #5 game_clock = ~game_clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- write monitors (sample mid-cycle) ----------------
  always @(negedge game_clock) begin
    if (wr_if.wr_en === 1'b1) got_q.push_back({wr_if.wr_addr, wr_if.wr_data});
    if (wr_small_if.wr_en === 1'b1) got_small_q.push_back({wr_small_if.wr_addr, wr_small_if.wr_data});
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge game_clock);
    #1;
  endtask

  task automatic do_beat(input logic [11:0] k);
    keys    = k;
    beat_en = 1'b1;
    tick();
    beat_en = 1'b0;
    tick();
  endtask

  // Drop record_en and wait (bounded) for the main instance to reach DONE.
  task automatic stop_record();
    bit reached;
    reached   = 1'b0;
    record_en = 1'b0;
    for (int i = 0; i < 8 && !reached; i++) begin
      tick();
      if (state_dbg == 2'd3) reached = 1'b1;
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL stop_timeout: state=%0d, required DONE(3) within 8 cycles", state_dbg);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", state_dbg); end
    checks++; if (wr_if.wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b exp 0", wr_if.wr_en); end
    checks++; if (wr_if.wr_addr !== 6'd0) begin errors++; $display("FAIL reset_wr_addr: got %0d exp 0", wr_if.wr_addr); end
    checks++; if (wr_if.wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %h exp 00", wr_if.wr_data); end
    checks++; if (entry_count !== 6'd0) begin errors++; $display("FAIL reset_entry_count: got %0d exp 0", entry_count); end
    checks++; if (busy !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL reset_flags: busy=%b overflow=%b exp 0 0", busy, overflow); end
    reset = 1'b0;
    tick();
  endtask

  // C,C,G,G,rest -> {0,2}@0 {7,2}@1 {15,1}@2
  task automatic test_basic();
    got_q.delete();
    exp_q.delete();
    exp_q.push_back({6'd0, 8'h02});
    exp_q.push_back({6'd1, 8'h72});
    exp_q.push_back({6'd2, 8'hF1});
    record_en = 1'b1;
    tick();
    checks++; if (busy !== 1'b1 || state_dbg !== 2'd1) begin errors++; $display("FAIL basic_busy: busy=%b state=%0d exp 1 1", busy, state_dbg); end
    do_beat(12'h001);
    do_beat(12'h001);
    do_beat(12'h080);
    do_beat(12'h080);
    do_beat(12'h000);
    checks++; if (entry_count !== 6'd2) begin errors++; $display("FAIL basic_mid_count: got %0d exp 2", entry_count); end
    stop_record();
    checks++; if (wr_if.wr_en !== 1'b1 || wr_if.wr_addr !== 6'd2 || wr_if.wr_data !== 8'hF1) begin
      errors++; $display("FAIL basic_flush_write: en=%b addr=%0d data=%h exp 1 2 f1", wr_if.wr_en, wr_if.wr_addr, wr_if.wr_data); end
    checks++; if (entry_count !== 6'd3) begin errors++; $display("FAIL basic_entry_count: got %0d exp 3", entry_count); end
    checks++; if (busy !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL basic_flags: busy=%b overflow=%b exp 0 0", busy, overflow); end
    tick();
    checks++; if (state_dbg !== 2'd0 || wr_if.wr_data !== 8'hF1) begin
      errors++; $display("FAIL basic_idle_hold: state=%0d data=%h exp 0 f1", state_dbg, wr_if.wr_data); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_write_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_write_%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  // 17 beats of G -> {7,15}@0 {7,2}@1
  task automatic test_long_run();
    got_q.delete();
    exp_q.delete();
    exp_q.push_back({6'd0, 8'h7F});
    exp_q.push_back({6'd1, 8'h72});
    record_en = 1'b1;
    tick();
    for (int b = 0; b < 17; b++) do_beat(12'h080);
    stop_record();
    checks++; if (entry_count !== 6'd2) begin errors++; $display("FAIL long_entry_count: got %0d exp 2", entry_count); end
    tick();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL long_write_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL long_write_%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  // Two keys held (bits 0 and 5) for 3 beats -> single {0,3}
  task automatic test_multi_key();
    got_q.delete();
    exp_q.delete();
    exp_q.push_back({6'd0, 8'h03});
    record_en = 1'b1;
    tick();
    for (int b = 0; b < 3; b++) do_beat(12'h021);
    stop_record();
    checks++; if (entry_count !== 6'd1) begin errors++; $display("FAIL multi_entry_count: got %0d exp 1", entry_count); end
    tick();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL multi_write_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL multi_write_%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  // Top key and mixed keys: 800, 0A0, 0A0, 800 -> {11,1} {5,2} {11,1}
  task automatic test_encoding();
    got_q.delete();
    exp_q.delete();
    exp_q.push_back({6'd0, 8'hB1});
    exp_q.push_back({6'd1, 8'h52});
    exp_q.push_back({6'd2, 8'hB1});
    record_en = 1'b1;
    tick();
    do_beat(12'h800);
    do_beat(12'h0A0);
    do_beat(12'h0A0);
    do_beat(12'h800);
    stop_record();
    tick();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL enc_write_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL enc_write_%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  // Small map (depth 4): C/D alternating for 6 beats -> 4 writes, then overflow
  task automatic test_full_map();
    got_small_q.delete();
    exp_small_q.delete();
    exp_small_q.push_back({3'd0, 8'h01});
    exp_small_q.push_back({3'd1, 8'h21});
    exp_small_q.push_back({3'd2, 8'h01});
    exp_small_q.push_back({3'd3, 8'h21});
    record_en = 1'b1;
    tick();
    checks++; if (overflow_small !== 1'b0) begin errors++; $display("FAIL full_ovf_start: got %b exp 0", overflow_small); end
    for (int b = 0; b < 3; b++) begin
      do_beat(12'h001);
      do_beat(12'h004);
    end
    checks++; if (state_dbg_small !== 2'd3) begin errors++; $display("FAIL full_state: got %0d exp 3", state_dbg_small); end
    checks++; if (overflow_small !== 1'b1) begin errors++; $display("FAIL full_overflow: got %b exp 1", overflow_small); end
    checks++; if (entry_count_small !== 3'd4) begin errors++; $display("FAIL full_entry_count: got %0d exp 4", entry_count_small); end
    checks++; if (busy_small !== 1'b0) begin errors++; $display("FAIL full_busy: got %b exp 0", busy_small); end
    // Further beats while DONE must not write anything.
    do_beat(12'h001);
    do_beat(12'h004);
    checks++; if (state_dbg_small !== 2'd3 || entry_count_small !== 3'd4) begin
      errors++; $display("FAIL full_hold: state=%0d count=%0d exp 3 4", state_dbg_small, entry_count_small); end
    stop_record();
    tick();
    checks++; if (overflow_small !== 1'b1) begin errors++; $display("FAIL full_ovf_sticky: got %b exp 1", overflow_small); end
    checks++; if (got_small_q.size() != exp_small_q.size()) begin errors++; $display("FAIL full_write_count: got %0d exp %0d", got_small_q.size(), exp_small_q.size()); end
    for (int i = 0; i < exp_small_q.size() && i < got_small_q.size(); i++) begin
      checks++; if (got_small_q[i] !== exp_small_q[i]) begin errors++; $display("FAIL full_write_%0d: got %h exp %h", i, got_small_q[i], exp_small_q[i]); end
    end
  endtask

  // Reset during RECORD with a pending run: no write, all outputs 0, fresh start at 0
  task automatic test_reset_mid_record();
    got_q.delete();
    exp_q.delete();
    exp_q.push_back({6'd0, 8'h71});
    record_en = 1'b1;
    tick();
    do_beat(12'h001);
    do_beat(12'h001);
    checks++; if (state_dbg !== 2'd1) begin errors++; $display("FAIL rmid_pre_state: got %0d exp 1", state_dbg); end
    reset = 1'b1;
    tick();
    checks++; if (state_dbg !== 2'd0 || busy !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL rmid_state: state=%0d busy=%b ovf=%b exp 0 0 0", state_dbg, busy, overflow); end
    checks++; if (wr_if.wr_en !== 1'b0 || wr_if.wr_addr !== 6'd0 || wr_if.wr_data !== 8'h00 || entry_count !== 6'd0) begin
      errors++; $display("FAIL rmid_outputs: en=%b addr=%0d data=%h count=%0d exp 0 0 00 0", wr_if.wr_en, wr_if.wr_addr, wr_if.wr_data, entry_count); end
    reset     = 1'b0;
    record_en = 1'b0;
    tick();
    tick();
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rmid_no_write: got %0d writes exp 0", got_q.size()); end
    record_en = 1'b1;
    tick();
    do_beat(12'h080);
    stop_record();
    tick();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rmid_write_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rmid_write_%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  // record_en drop coincides with beat_en; then re-raise while in DONE
  task automatic test_stop_edge();
    got_q.delete();
    exp_q.delete();
    exp_q.push_back({6'd0, 8'h02});
    record_en = 1'b1;
    tick();
    do_beat(12'h001);
    do_beat(12'h001);
    keys      = 12'h001;
    beat_en   = 1'b1;
    record_en = 1'b0;
    tick();
    checks++; if (state_dbg !== 2'd2) begin errors++; $display("FAIL edge_flush_state: got %0d exp 2", state_dbg); end
    beat_en   = 1'b0;
    record_en = 1'b1;   // re-raised before DONE has seen it low
    tick();
    checks++; if (wr_if.wr_en !== 1'b1 || wr_if.wr_data !== 8'h02 || wr_if.wr_addr !== 6'd0) begin
      errors++; $display("FAIL edge_flush_write: en=%b addr=%0d data=%h exp 1 0 02", wr_if.wr_en, wr_if.wr_addr, wr_if.wr_data); end
    do_beat(12'h080);
    do_beat(12'h080);
    checks++; if (state_dbg !== 2'd3 || busy !== 1'b0 || entry_count !== 6'd1) begin
      errors++; $display("FAIL edge_done_hold: state=%0d busy=%b count=%0d exp 3 0 1", state_dbg, busy, entry_count); end
    record_en = 1'b0;
    tick();
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL edge_idle: got %0d exp 0", state_dbg); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL edge_write_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL edge_write_%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_long_run();
    test_multi_key();
    test_encoding();
    test_full_map();
    test_reset_mid_record();
    test_stop_edge();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
